pipeline_sequencer: RTL and testbench



---
 rtl/echo_pkg.sv | 34 +++
 rtl/stage_handshake.sv | 64 ++++++
 rtl/pipeline_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : echo_pkg
//  Description : Shared constants for the echo-cancellation sequencer:
//                FSM state encoding, timeout_err bit positions, out_sel
//                encodings and the default frame length.
//  Revision    : 1.0 - initial release
// ============================================================================
package echo_pkg;

    // Default number of operation clocks per sample frame.
    localparam int DEFAULT_SAMPLING_CYCLE = 1510;

    // Sequencer FSM state encoding (fixed 3-bit width).
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_CONV   = 3'd1;
    localparam state_t c_ST_LAG    = 3'd2;
    localparam state_t c_ST_APPROX = 3'd3;
    localparam state_t c_ST_CANCEL = 3'd4;
    localparam state_t c_ST_OUT    = 3'd5;

    // Bit positions inside timeout_err: [conv, lag, approx, cancel].
    localparam int c_TO_CONV   = 3;
    localparam int c_TO_LAG    = 2;
    localparam int c_TO_APPROX = 1;
    localparam int c_TO_CANCEL = 0;

    // Output converter source selection.
    localparam logic OUT_SEL_E      = 1'b0;  // adaptation error e
    localparam logic OUT_SEL_CANCEL = 1'b1;  // signal_without_echo

endpackage : echo_pkg
`default_nettype wire

// File: rtl/stage_handshake.sv
`default_nettype none
// ============================================================================
//  Module      : stage_handshake
//  Description : Shared per-stage handshake helper. Counts clocks since the
//                current stage state was entered, produces the enable pulse
//                window, qualifies the stage ready only after the pulse has
//                ended, and flags a timeout on the last allowed wait clock.
//  Ports       : clk_operation  - operation clock
//                rst            - asynchronous active-low reset
//                i_restart      - current clock enters a stage state
//                i_ready        - ready of the stage currently being served
//                o_pulse_next   - enable pulse active in the next clock
//                o_ready_ok     - ready seen after the pulse window
//                o_timed_out    - last wait clock passed without ready
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_handshake #(
    parameter int PULSE_LEN = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic clk_operation,
    input  logic rst,
    input  logic i_restart,
    input  logic i_ready,
    output logic o_pulse_next,
    output logic o_ready_ok,
    output logic o_timed_out
);

    localparam int                  c_WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_PULSE  = c_WAIT_W'(PULSE_LEN);
    localparam logic [c_WAIT_W-1:0] c_LAST   = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0] c_ONE    = c_WAIT_W'(1);

    // r_wait = number of clocks already spent in the current stage state.
    logic [c_WAIT_W-1:0] r_wait;
    logic [c_WAIT_W-1:0] w_wait_nxt;

    // Saturates at the last wait value so an idle FSM cannot wrap it.
    always_comb begin
        w_wait_nxt = r_wait;
        if (i_restart) begin
            w_wait_nxt = '0;
        end else if (r_wait != c_LAST) begin
            w_wait_nxt = r_wait + c_ONE;
        end
    end

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else begin
            r_wait <= w_wait_nxt;
        end
    end

    // Looks one clock ahead so the caller can register its enable outputs.
    assign o_pulse_next = (w_wait_nxt < c_PULSE);
    // Stages drop ready once enabled; anything seen during the pulse is stale.
    assign o_ready_ok   = i_ready && (r_wait >= c_PULSE);
    assign o_timed_out  = (r_wait == c_LAST) && !o_ready_ok;

endmodule : stage_handshake
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_sequencer
//  Description : Per-sample controller of the echo-cancellation chain. Owns
//                the free-running sampling counter and steps each frame
//                through conv -> lag -> approx|cancel -> out using
//                ready-driven handshakes with timeout and overrun detection.
//                Switches from adaptation to cancellation after MAX_ITER
//                completed adaptation frames.
//  Ports       : clk_operation, rst (async, active-low), run, ready_* (in);
//                sampling_cycle_counter, sampling_light, enable_*, out_sel,
//                adapt_mode, iteration, timeout_err, overrun, busy (out,
//                all registered).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_sequencer
    import echo_pkg::*;
#(
    parameter int SAMPLING_CYCLE = DEFAULT_SAMPLING_CYCLE,
    parameter int CNT_W          = 13,
    parameter int MAX_ITER       = 20,
    parameter int ITER_W         = 8,
    parameter int PULSE_LEN      = 2,
    parameter int TIMEOUT        = 1024
) (
    input  logic              clk_operation,
    input  logic              rst,
    input  logic              run,
    input  logic              ready_conv,
    input  logic              ready_lag,
    input  logic              ready_approx,
    input  logic              ready_cancel,
    output logic [CNT_W-1:0]  sampling_cycle_counter,
    output logic              sampling_light,
    output logic              enable_conv,
    output logic              enable_lag,
    output logic              enable_approx,
    output logic              enable_cancel,
    output logic              enable_sampling,
    output logic              enable_out,
    output logic              out_sel,
    output logic              adapt_mode,
    output logic [ITER_W-1:0] iteration,
    output logic [3:0]        timeout_err,
    output logic              overrun,
    output logic              busy
);

    localparam logic [CNT_W-1:0]  c_LAST_CNT = CNT_W'(SAMPLING_CYCLE - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [ITER_W-1:0] c_MAX_ITER = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] c_ITER_ONE = ITER_W'(1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_cnt_run;
    logic              r_light;
    state_t            r_state;
    logic              r_en_conv, r_en_lag, r_en_approx, r_en_cancel;
    logic              r_en_sampling, r_en_out, r_out_sel, r_adapt;
    logic [ITER_W-1:0] r_iter;
    logic [3:0]        r_to_err;
    logic              r_ovr, r_busy;

    logic [CNT_W-1:0]  w_cnt_nxt;
    state_t            w_state_nxt;
    logic              w_restart, w_ready_sel, w_in_stage;
    logic              w_pulse_nxt, w_ready_ok, w_timed_out;
    logic [3:0]        w_to_set;
    logic              w_ovr_set, w_samp_set, w_iter_inc, w_sel_nxt;

    // The counter holds 0 for the first clock after reset so that
    // sampling_light (our registered "counter == 0") rises on that clock.
    always_comb begin
        w_cnt_nxt = r_cnt + c_CNT_ONE;
        if (!r_cnt_run || (r_cnt == c_LAST_CNT)) begin
            w_cnt_nxt = '0;
        end
    end

    always_comb begin
        w_ready_sel = 1'b0;
        case (r_state)
            c_ST_CONV:   w_ready_sel = ready_conv;
            c_ST_LAG:    w_ready_sel = ready_lag;
            c_ST_APPROX: w_ready_sel = ready_approx;
            c_ST_CANCEL: w_ready_sel = ready_cancel;
            default:     w_ready_sel = 1'b0;
        endcase
    end

    assign w_in_stage = (r_state == c_ST_CONV)   || (r_state == c_ST_LAG) ||
                        (r_state == c_ST_APPROX) || (r_state == c_ST_CANCEL);

    stage_handshake #(
        .PULSE_LEN (PULSE_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_handshake (
        .clk_operation (clk_operation),
        .rst           (rst),
        .i_restart     (w_restart),
        .i_ready       (w_ready_sel),
        .o_pulse_next  (w_pulse_nxt),
        .o_ready_ok    (w_ready_ok),
        .o_timed_out   (w_timed_out)
    );

    // w_restart marks every entry into a stage state, including CONV->CONV
    // when an overrun aborts a frame that was still in conversion.
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_to_set    = 4'b0000;
        w_ovr_set   = 1'b0;
        w_samp_set  = 1'b0;
        w_iter_inc  = 1'b0;
        w_sel_nxt   = r_out_sel;
        if (r_light && w_in_stage) begin
            w_ovr_set   = 1'b1;
            w_state_nxt = run ? c_ST_CONV : c_ST_IDLE;
            w_restart   = run;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_light && run) begin
                        w_state_nxt = c_ST_CONV;
                        w_restart   = 1'b1;
                    end
                end
                c_ST_CONV: begin
                    if (w_ready_ok) begin
                        w_state_nxt = c_ST_LAG;
                        w_restart   = 1'b1;
                    end else if (w_timed_out) begin
                        w_to_set[c_TO_CONV] = 1'b1;
                        w_state_nxt         = c_ST_IDLE;
                    end
                end
                c_ST_LAG: begin
                    if (w_ready_ok) begin
                        w_samp_set  = 1'b1;
                        w_state_nxt = r_adapt ? c_ST_APPROX : c_ST_CANCEL;
                        w_restart   = 1'b1;
                    end else if (w_timed_out) begin
                        w_to_set[c_TO_LAG] = 1'b1;
                        w_state_nxt        = c_ST_IDLE;
                    end
                end
                c_ST_APPROX: begin
                    if (w_ready_ok) begin
                        w_state_nxt = c_ST_OUT;
                        w_sel_nxt   = OUT_SEL_E;
                        w_iter_inc  = 1'b1;
                    end else if (w_timed_out) begin
                        w_to_set[c_TO_APPROX] = 1'b1;
                        w_state_nxt           = c_ST_IDLE;
                    end
                end
                c_ST_CANCEL: begin
                    if (w_ready_ok) begin
                        w_state_nxt = c_ST_OUT;
                        w_sel_nxt   = OUT_SEL_CANCEL;
                    end else if (w_timed_out) begin
                        w_to_set[c_TO_CANCEL] = 1'b1;
                        w_state_nxt           = c_ST_IDLE;
                    end
                end
                c_ST_OUT: begin
                    // A frame finishing exactly at the wrap is not an overrun;
                    // the next frame still starts on time.
                    w_state_nxt = (r_light && run) ? c_ST_CONV : c_ST_IDLE;
                    w_restart   = r_light && run;
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_cnt_run     <= 1'b0;
            r_light       <= 1'b0;
            r_state       <= c_ST_IDLE;
            r_en_conv     <= 1'b0;
            r_en_lag      <= 1'b0;
            r_en_approx   <= 1'b0;
            r_en_cancel   <= 1'b0;
            r_en_sampling <= 1'b0;
            r_en_out      <= 1'b0;
            r_out_sel     <= OUT_SEL_E;
            r_adapt       <= 1'b1;
            r_iter        <= '0;
            r_to_err      <= 4'b0000;
            r_ovr         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_cnt_run   <= 1'b1;
            r_light     <= (w_cnt_nxt == '0);
            r_state     <= w_state_nxt;
            r_en_conv   <= (w_state_nxt == c_ST_CONV)   && w_pulse_nxt;
            r_en_lag    <= (w_state_nxt == c_ST_LAG)    && w_pulse_nxt;
            r_en_approx <= (w_state_nxt == c_ST_APPROX) && w_pulse_nxt;
            r_en_cancel <= (w_state_nxt == c_ST_CANCEL) && w_pulse_nxt;
            r_en_out    <= (w_state_nxt == c_ST_OUT);
            r_busy      <= (w_state_nxt != c_ST_IDLE);
            r_out_sel   <= w_sel_nxt;
            r_to_err    <= r_to_err | w_to_set;
            if (w_samp_set) begin
                r_en_sampling <= 1'b1;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end
            if (w_iter_inc && (r_iter < c_MAX_ITER)) begin
                r_iter <= r_iter + c_ITER_ONE;
            end
            // Mode switches only as a frame retires, so routing in LAG never
            // sees a mode change within the same frame.
            if ((r_state == c_ST_OUT) && (r_iter >= c_MAX_ITER)) begin
                r_adapt <= 1'b0;
            end
        end
    end

    assign sampling_cycle_counter = r_cnt;
    assign sampling_light         = r_light;
    assign enable_conv            = r_en_conv;
    assign enable_lag             = r_en_lag;
    assign enable_approx          = r_en_approx;
    assign enable_cancel          = r_en_cancel;
    assign enable_sampling        = r_en_sampling;
    assign enable_out             = r_en_out;
    assign out_sel                = r_out_sel;
    assign adapt_mode             = r_adapt;
    assign iteration              = r_iter;
    assign timeout_err            = r_to_err;
    assign overrun                = r_ovr;
    assign busy                   = r_busy;

endmodule : pipeline_sequencer
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_sequencer
//  Description : Directed self-checking bench for pipeline_sequencer.
//                Main instance: SAMPLING_CYCLE=40, PULSE_LEN=2, TIMEOUT=8,
//                MAX_ITER=3. A second instance with TIMEOUT=64 is held in
//                reset until the overrun scenario, since an 8-clock stage
//                timeout cannot let a frame span a 40-clock wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam int SC  = 40;
    localparam int PL  = 2;
    localparam int TO  = 8;
    localparam int TO2 = 64;
    localparam int MI  = 3;
    localparam int CW  = 13;
    localparam int IW  = 8;

    logic clk_operation = 1'b0;
    always #5 clk_operation = ~clk_operation;

    logic rst, rst_ovr, run;
    logic ready_conv, ready_lag, ready_approx, ready_cancel, ready_approx_ovr;

    logic [CW-1:0] cnt, cnt_o;
    logic          light, light_o;
    logic          en_conv, en_lag, en_approx, en_cancel, en_smp, en_out, out_sel, adapt;
    logic          en_conv_o, en_lag_o, en_approx_o, en_cancel_o, en_smp_o, en_out_o, out_sel_o, adapt_o;
    logic [IW-1:0] iter, iter_o;
    logic [3:0]    to_err, to_err_o;
    logic          ovr, ovr_o, busy, busy_o;
    logic [4:0]    en_vec, en_vec_o;

    assign en_vec   = {en_conv, en_lag, en_approx, en_cancel, en_out};
    assign en_vec_o = {en_conv_o, en_lag_o, en_approx_o, en_cancel_o, en_out_o};

    pipeline_sequencer #(
        .SAMPLING_CYCLE(SC), .CNT_W(CW), .MAX_ITER(MI), .ITER_W(IW),
        .PULSE_LEN(PL), .TIMEOUT(TO)
    ) dut (
        .clk_operation(clk_operation), .rst(rst), .run(run),
        .ready_conv(ready_conv), .ready_lag(ready_lag),
        .ready_approx(ready_approx), .ready_cancel(ready_cancel),
        .sampling_cycle_counter(cnt), .sampling_light(light),
        .enable_conv(en_conv), .enable_lag(en_lag), .enable_approx(en_approx),
        .enable_cancel(en_cancel), .enable_sampling(en_smp), .enable_out(en_out),
        .out_sel(out_sel), .adapt_mode(adapt), .iteration(iter),
        .timeout_err(to_err), .overrun(ovr), .busy(busy)
    );

    pipeline_sequencer #(
        .SAMPLING_CYCLE(SC), .CNT_W(CW), .MAX_ITER(MI), .ITER_W(IW),
        .PULSE_LEN(PL), .TIMEOUT(TO2)
    ) dut_ovr (
        .clk_operation(clk_operation), .rst(rst_ovr), .run(run),
        .ready_conv(ready_conv), .ready_lag(ready_lag),
        .ready_approx(ready_approx_ovr), .ready_cancel(ready_cancel),
        .sampling_cycle_counter(cnt_o), .sampling_light(light_o),
        .enable_conv(en_conv_o), .enable_lag(en_lag_o), .enable_approx(en_approx_o),
        .enable_cancel(en_cancel_o), .enable_sampling(en_smp_o), .enable_out(en_out_o),
        .out_sel(out_sel_o), .adapt_mode(adapt_o), .iteration(iter_o),
        .timeout_err(to_err_o), .overrun(ovr_o), .busy(busy_o)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_operation);
        #1;
    endtask

    function automatic int cur_cnt(input bit which);
        return which ? int'(cnt_o) : int'(cnt);
    endfunction

    task automatic go_to(input int k, input bit which);
        int n;
        n = 0;
        while ((cur_cnt(which) != k) && (n < 100)) begin
            step();
            n++;
        end
        if (cur_cnt(which) != k) chk("goto_bound", cur_cnt(which), k);
    endtask

    // Expected {conv, lag, approx, cancel, out} at counter k of a frame that
    // starts at counter 0 with every ready already high.
    function automatic logic [4:0] exp_en(input int k, input bit adp);
        logic c, l, a, x, o;
        c = (k == 1) || (k == 2);
        l = (k == 4) || (k == 5);
        a = adp  && ((k == 7) || (k == 8));
        x = !adp && ((k == 7) || (k == 8));
        o = (k == 10);
        return {c, l, a, x, o};
    endfunction

    task automatic run_frame(input bit adp, input int exp_it, input bit exp_sel, input bit adapt_after);
        go_to(1, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("en_vec_k%0d_it%0d", k, exp_it), en_vec, exp_en(k, adp));
            if (k == 10) begin
                chk($sformatf("out_sel_it%0d", exp_it), out_sel, exp_sel);
                chk($sformatf("iteration_it%0d", exp_it), iter, exp_it);
            end
            if (k == 11) chk($sformatf("adapt_after_it%0d", exp_it), adapt, adapt_after);
            step();
        end
    endtask

    initial begin
        logic saw_out;
        rst = 1'b0; rst_ovr = 1'b0; run = 1'b1;
        ready_conv = 1'b1; ready_lag = 1'b1; ready_approx = 1'b1; ready_cancel = 1'b1;
        ready_approx_ovr = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_cnt", cnt, 0);
        chk("rst_light", light, 0);
        chk("rst_en", en_vec, 5'b00000);
        chk("rst_en_smp", en_smp, 0);
        chk("rst_adapt", adapt, 1);
        chk("rst_iter", iter, 0);
        chk("rst_to_err", to_err, 0);
        chk("rst_busy", busy, 0);

        rst = 1'b1;
        step();
        chk("rel_cnt", cnt, 0);
        chk("rel_light", light, 1);
        chk("rel_busy", busy, 0);

        // Three adaptation frames then a cancellation frame
        run_frame(1'b1, 1, 1'b0, 1'b1);
        chk("en_sampling_set", en_smp, 1);
        run_frame(1'b1, 2, 1'b0, 1'b1);
        run_frame(1'b1, 3, 1'b0, 1'b0);
        run_frame(1'b0, 3, 1'b1, 1'b0);
        chk("no_to_err", to_err, 4'b0000);
        chk("no_overrun", ovr, 0);

        // Lag stage never ready -> timeout 8 clocks after LAG entry (count 4)
        ready_lag = 1'b0;
        go_to(11, 1'b0);
        chk("to_pre_err", to_err, 4'b0000);
        chk("to_pre_busy", busy, 1);
        step();
        chk("to_err_lag", to_err, 4'b0100);
        chk("to_busy", busy, 0);
        chk("to_en", en_vec, 5'b00000);
        saw_out = 1'b0;
        for (int i = 0; i < 27; i++) begin
            saw_out = saw_out | en_out;
            step();
        end
        chk("to_no_out", saw_out, 0);
        ready_lag = 1'b1;
        go_to(1, 1'b0);
        chk("to_restart_conv", en_conv, 1);
        go_to(10, 1'b0);
        chk("to_restart_out", en_out, 1);
        chk("to_restart_sel", out_sel, 1);

        // Ready high during the CONV pulse and low just after it
        go_to(2, 1'b0);
        chk("rq_conv_k2", en_conv, 1);
        chk("rq_lag_k2", en_lag, 0);
        step();
        ready_conv = 1'b0;
        step();
        chk("rq_lag_k4", en_lag, 0);
        chk("rq_busy_k4", busy, 1);
        ready_conv = 1'b1;
        step();
        chk("rq_lag_k5", en_lag, 1);
        step();
        chk("rq_lag_k6", en_lag, 1);
        step();
        chk("rq_lag_k7", en_lag, 0);
        step();
        chk("rq_cancel_k8", en_cancel, 1);
        repeat (3) step();
        chk("rq_out_k11", en_out, 1);

        // Asynchronous reset during LAG
        go_to(4, 1'b0);
        chk("ar_lag_pre", en_lag, 1);
        rst = 1'b0;
        #1;
        chk("ar_en", en_vec, 5'b00000);
        chk("ar_iter", iter, 0);
        chk("ar_adapt", adapt, 1);
        chk("ar_to_err", to_err, 0);
        chk("ar_en_smp", en_smp, 0);
        chk("ar_cnt", cnt, 0);
        step();
        rst = 1'b1;
        step();
        chk("ar_light", light, 1);
        step();
        chk("ar_conv_k1", en_conv, 1);
        chk("ar_cnt_k1", cnt, 1);
        step();
        chk("ar_conv_k2", en_conv, 1);
        step();
        chk("ar_conv_k3", en_conv, 0);

        // Overrun: approx ready withheld across the wrap (TIMEOUT=64 instance)
        rst_ovr = 1'b1;
        go_to(7, 1'b1);
        chk("ov_approx_k7", en_approx_o, 1);
        go_to(0, 1'b1);
        chk("ov_pre_flag", ovr_o, 0);
        chk("ov_pre_busy", busy_o, 1);
        step();
        chk("ov_flag", ovr_o, 1);
        chk("ov_conv_k1", en_conv_o, 1);
        chk("ov_no_to", to_err_o, 4'b0000);
        step();
        chk("ov_conv_k2", en_conv_o, 1);
        ready_approx_ovr = 1'b1;
        go_to(10, 1'b1);
        chk("ov_out", en_out_o, 1);
        chk("ov_sel", out_sel_o, 0);
        chk("ov_iter", iter_o, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_pipeline_sequencer
`default_nettype wire
